// File: rtl/qed_dup_scheduler_if.sv
// Fetch/decode handshake bundle for the QED duplicate scheduler.
// The scheduler connects through the slave modport. The fetch/decode side connects through the master modport.
interface qed_dup_scheduler_if;
  logic        in_vld;
  logic [31:0] in_instr;
  logic        in_rdy;
  logic        out_stall;
  logic        out_vld;
  logic [31:0] out_instr;
  logic        out_is_dup;

  modport master (
    output in_vld, in_instr, out_stall,
    input  in_rdy, out_vld, out_instr, out_is_dup
  );

  modport slave (
    input  in_vld, in_instr, out_stall,
    output in_rdy, out_vld, out_instr, out_is_dup
  );
endinterface

// File: rtl/qed_dup_scheduler.sv
// SQED fetch-to-decode scheduler. It forwards each original instruction, buffers the duplicable ones,
// and then replays them as duplicates with every register field shifted into the upper half of the register file.
module qed_dup_scheduler #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DUP_OFFSET = 16
) (
  input  logic                         clk,
  input  logic                         outside_reset,
  input  logic                         qed_exec_dup,
  qed_dup_scheduler_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [15:0]                  orig_cnt,
  output logic [15:0]                  dup_cnt,
  output logic                         qed_ready,
  output logic                         err_range
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [4:0]  OFF = 5'(DUP_OFFSET);

  localparam logic [0:0] S_ORIG = 1'b0;
  localparam logic [0:0] S_DUP  = 1'b1;

  // Field-use mask {rd, rs1, rs2}; zero means the opcode is not duplicated.
  function automatic logic [2:0] field_mask(input logic [6:0] op);
    case (op)
      7'b0110011:             field_mask = 3'b111;
      7'b0010011, 7'b0000011: field_mask = 3'b110;
      7'b0100011, 7'b1100011: field_mask = 3'b011;
      7'b0110111, 7'b0010111: field_mask = 3'b100;
      default:                field_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] remap(input logic [31:0] ins);
    logic [2:0] m;
    m     = field_mask(ins[6:0]);
    remap = ins;
    if (m[2] && ins[11:7]  != 5'd0) remap[11:7]  = ins[11:7]  + OFF;
    if (m[1] && ins[19:15] != 5'd0) remap[19:15] = ins[19:15] + OFF;
    if (m[0] && ins[24:20] != 5'd0) remap[24:20] = ins[24:20] + OFF;
  endfunction

  function automatic logic out_of_range(input logic [31:0] ins);
    logic [2:0] m;
    m = field_mask(ins[6:0]);
    out_of_range = (m[2] && ins[11:7] >= OFF) || (m[1] && ins[19:15] >= OFF) ||
                   (m[0] && ins[24:20] >= OFF);
  endfunction

  logic [0:0]    state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_vld_q, out_vld_d;
  logic [31:0]   out_instr_q, out_instr_d;
  logic          out_is_dup_q, out_is_dup_d;
  logic [15:0]   orig_cnt_q, orig_cnt_d, dup_cnt_q, dup_cnt_d;
  logic          err_range_q, err_range_d;
  logic          in_rdy, accept, push;
  logic [CW-1:0] count_post;

  assign in_rdy = (state_q == S_ORIG) && !bus.out_stall && (count_q < CW'(DEPTH));
  assign accept = bus.in_vld && in_rdy;

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_is_dup_d = out_is_dup_q;
    orig_cnt_d   = orig_cnt_q;
    dup_cnt_d    = dup_cnt_q;
    err_range_d  = err_range_q;
    push         = 1'b0;
    count_post   = count_q;
    if (!bus.out_stall) begin
      if (state_q == S_ORIG) begin
        out_vld_d = accept;
        if (accept) begin
          out_instr_d  = bus.in_instr;
          out_is_dup_d = 1'b0;
          if (field_mask(bus.in_instr[6:0]) != 3'b000) begin
            if (out_of_range(bus.in_instr)) err_range_d = 1'b1;
            else                            push        = 1'b1;
          end
        end
        if (push) begin
          mem_d[wr_ptr_q] = bus.in_instr;
          wr_ptr_d        = wr_ptr_q + PW'(1);
          orig_cnt_d      = orig_cnt_q + 16'd1;
          count_post      = count_q + CW'(1);
        end
        count_d = count_post;
        // The exit test uses the post-push count, so a same-cycle accept joins the burst.
        if (count_post != '0 && (qed_exec_dup || count_post == CW'(DEPTH)))
          state_d = S_DUP;
      end else begin
        out_vld_d    = 1'b1;
        out_instr_d  = remap(mem_q[rd_ptr_q]);
        out_is_dup_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PW'(1);
        count_d      = count_q - CW'(1);
        dup_cnt_d    = dup_cnt_q + 16'd1;
        if (count_q == CW'(1)) state_d = S_ORIG;
      end
    end
  end

  always_ff @(posedge clk or posedge outside_reset) begin
    if (outside_reset) begin
      state_q      <= S_ORIG;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_vld_q    <= 1'b0;
      out_instr_q  <= '0;
      out_is_dup_q <= 1'b0;
      orig_cnt_q   <= '0;
      dup_cnt_q    <= '0;
      err_range_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_is_dup_q <= out_is_dup_d;
      orig_cnt_q   <= orig_cnt_d;
      dup_cnt_q    <= dup_cnt_d;
      err_range_q  <= err_range_d;
    end
  end

  assign bus.in_rdy     = in_rdy;
  assign bus.out_vld    = out_vld_q;
  assign bus.out_instr  = out_instr_q;
  assign bus.out_is_dup = out_is_dup_q;
  assign fifo_count     = count_q;
  assign orig_cnt       = orig_cnt_q;
  assign dup_cnt        = dup_cnt_q;
  assign qed_ready      = (orig_cnt_q == dup_cnt_q) && (orig_cnt_q != 16'd0);
  assign err_range      = err_range_q;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Self-checking bench for qed_dup_scheduler. It uses directed scenarios followed by random traffic.
// All checks compare the DUT against a queue-based reference model.
module tb_qed_dup_scheduler;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OFF   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec;
  logic [2:0]  fifo_count;
  logic [15:0] orig_cnt, dup_cnt;
  logic        qed_ready, err_range;

  always #5 clk = ~clk;

  qed_dup_scheduler_if bus ();

  qed_dup_scheduler #(.DEPTH(DEPTH), .DUP_OFFSET(OFF)) dut (
    .clk          (clk),
    .outside_reset(rst),
    .qed_exec_dup (exec),
    .bus          (bus.slave),
    .fifo_count   (fifo_count),
    .orig_cnt     (orig_cnt),
    .dup_cnt      (dup_cnt),
    .qed_ready    (qed_ready),
    .err_range    (err_range)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_burst;
  logic        m_vld, m_dup, m_err;
  logic [31:0] m_instr;
  logic [15:0] m_orig, m_dupc;
  int          pos[3] = '{7, 15, 20};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // f: 0=rd, 1=rs1, 2=rs2
  function automatic bit uses(input logic [31:0] ins, input int f);
    logic [6:0] op;
    op = ins[6:0];
    case (f)
      0:       uses = op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17};
      1:       uses = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
      default: uses = op inside {7'h33, 7'h23, 7'h63};
    endcase
  endfunction

  function automatic bit dupable(input logic [31:0] ins);
    dupable = uses(ins, 0) || uses(ins, 1) || uses(ins, 2);
  endfunction

  function automatic bit bad_reg(input logic [31:0] ins);
    bad_reg = 1'b0;
    for (int f = 0; f < 3; f++)
      if (uses(ins, f) && ((ins >> pos[f]) & 32'h1f) >= OFF) bad_reg = 1'b1;
  endfunction

  function automatic logic [31:0] remap_m(input logic [31:0] ins);
    logic [31:0] v;
    remap_m = ins;
    for (int f = 0; f < 3; f++) begin
      v = (ins >> pos[f]) & 32'h1f;
      if (uses(ins, f) && v != 0) begin
        v = (v + OFF) % 32;
        remap_m = (remap_m & ~(32'h1f << pos[f])) | (v << pos[f]);
      end
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    m_burst = 0; m_vld = 0; m_dup = 0; m_err = 0;
    m_instr = '0; m_orig = '0; m_dupc = '0;
  endtask

  task automatic check_outs();
    chk("out_vld", bus.out_vld, m_vld);
    if (m_vld) begin
      chk("out_instr", bus.out_instr, m_instr);
      chk("out_is_dup", bus.out_is_dup, m_dup);
    end
    chk("fifo_count", fifo_count, mq.size());
    chk("orig_cnt", orig_cnt, m_orig);
    chk("dup_cnt", dup_cnt, m_dupc);
    chk("qed_ready", qed_ready, (m_orig == m_dupc) && (m_orig != 0));
    chk("err_range", err_range, m_err);
  endtask

  // Called at posedge+1. Drives one cycle, advances the model, and checks at the next posedge+1.
  task automatic cycle(input logic vld, input logic [31:0] ins, input logic ex, input logic st);
    bit exp_rdy;
    logic [31:0] h;
    bus.in_vld = vld; bus.in_instr = ins; exec = ex; bus.out_stall = st;
    #1;
    exp_rdy = !m_burst && !st && (mq.size() < DEPTH);
    chk("in_rdy", bus.in_rdy, exp_rdy);
    if (!st) begin
      if (!m_burst) begin
        m_vld = vld && exp_rdy;
        if (m_vld) begin
          m_instr = ins; m_dup = 0;
          if (dupable(ins)) begin
            if (bad_reg(ins)) m_err = 1;
            else begin mq.push_back(ins); m_orig++; end
          end
        end
        if (mq.size() != 0 && (ex || mq.size() == DEPTH)) m_burst = 1;
      end else begin
        h = mq.pop_front();
        m_vld = 1; m_instr = remap_m(h); m_dup = 1; m_dupc++;
        if (mq.size() == 0) m_burst = 0;
      end
    end
    @(posedge clk); #1;
    check_outs();
  endtask

  // Asserts reset mid-cycle and checks that it takes effect immediately. Returns at posedge+1.
  task automatic async_reset();
    bus.in_vld = 0; bus.in_instr = '0; exec = 0; bus.out_stall = 0;
    #2 rst = 1;
    #1;
    chk("rst_out_vld", bus.out_vld, 1'b0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_orig_cnt", orig_cnt, 16'd0);
    chk("rst_dup_cnt", dup_cnt, 16'd0);
    chk("rst_err_range", err_range, 1'b0);
    chk("rst_in_rdy", bus.in_rdy, 1'b1);
    model_reset();
    @(posedge clk); #2 rst = 0;
    @(posedge clk); #1;
    check_outs();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h73};
    logic [31:0] ins;
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 19) != 0) begin
      ins[11] = 1'b0; ins[19] = 1'b0; ins[24] = 1'b0;
    end
    return ins;
  endfunction

  initial begin
    bus.in_vld = 0; bus.in_instr = '0; exec = 0; bus.out_stall = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    chk("reset_out_instr", bus.out_instr, 32'h0);
    chk("reset_in_rdy", bus.in_rdy, 1'b1);
    rst = 0;

    // ADD x3,x1,x2 followed by its duplicate
    cycle(1, 32'h002081B3, 1, 0);
    chk("t2_orig_instr", bus.out_instr, 32'h002081B3);
    chk("t2_orig_isdup", bus.out_is_dup, 1'b0);
    cycle(0, '0, 0, 0);
    chk("t2_dup_instr", bus.out_instr, 32'h012889B3);
    chk("t2_dup_isdup", bus.out_is_dup, 1'b1);
    chk("t2_qed_ready", qed_ready, 1'b1);

    // ADDI x5,x0,7 keeps x0, and JAL is not buffered
    cycle(1, 32'h00700293, 1, 0);
    cycle(0, '0, 0, 0);
    chk("t3_dup_instr", bus.out_instr, 32'h00700A93);
    cycle(1, 32'h008000EF, 0, 0);
    chk("t3_jal_instr", bus.out_instr, 32'h008000EF);
    chk("t3_jal_fifo", fifo_count, 3'd0);
    chk("t3_jal_orig", orig_cnt, 16'd2);

    // A full FIFO forces the burst
    async_reset();
    for (int k = 0; k < 4; k++) cycle(1, 32'h00208033 | ((k + 4) << 7), 0, 0);
    chk("t4_full_in_rdy", bus.in_rdy, 1'b0);
    chk("t4_full_fifo", fifo_count, 3'd4);
    for (int k = 0; k < 4; k++) begin
      cycle(0, '0, 0, 0);
      chk("t4_dup_instr", bus.out_instr, 32'h01288033 | ((k + 20) << 7));
    end
    chk("t4_orig_cnt", orig_cnt, 16'd4);
    chk("t4_dup_cnt", dup_cnt, 16'd4);

    // Stall during a burst, then reset mid-burst with fifo_count=2
    for (int k = 0; k < 3; k++) cycle(1, 32'h00208033 | ((k + 4) << 7), 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, '0, 1, 1);
      chk("t5_held_instr", bus.out_instr, 32'h01288033 | (20 << 7));
      chk("t5_held_fifo", fifo_count, 3'd2);
      chk("t5_held_dupcnt", dup_cnt, 16'd5);
    end
    async_reset();

    // An out-of-range original is forwarded, and err_range stays set
    cycle(1, 32'h00208A33, 0, 0);
    chk("t6_fwd_instr", bus.out_instr, 32'h00208A33);
    chk("t6_err", err_range, 1'b1);
    chk("t6_orig", orig_cnt, 16'd0);
    cycle(1, 32'h002081B3, 0, 0);
    chk("t6_err_sticky", err_range, 1'b1);
    chk("t6_fifo", fifo_count, 3'd1);

    // Random traffic
    async_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset();
      cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
